gr_heep_obi_demux: RTL and testbench

Parametrised 1-to-N OBI demultiplexer with in-order outstanding-transaction tracking and a built-in decode-error responder. It is the slave-side stage of the next-generation external crossbar. It replaces the zero-state 1-to-M split with one that supports pipelined requests, configurable data/address width and explicit error responses. It sits between the crossbar neck (or a single master) and the external slave ports.

---
 rtl/gr_heep_obi_demux.sv | 192 +++++++++++++++++++
 tb/tb_gr_heep_obi_demux.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gr_heep_obi_demux.sv
// 1-to-NSLAVE OBI demultiplexer with in-order outstanding tracking and an
// internal decode-error responder for unmapped addresses.
module gr_heep_obi_demux #(
   parameter int unsigned NSLAVE          = 6,
   parameter int unsigned ADDR_WIDTH      = 32,
   parameter int unsigned DATA_WIDTH      = 32,
   parameter int unsigned MAX_OUTSTANDING = 4,
   parameter bit          ERR_RESP_EN     = 1'b1,
   localparam int unsigned IDX_W          = (NSLAVE > 1) ? $clog2(NSLAVE) : 1,
   localparam int unsigned CNT_W          = $clog2(MAX_OUTSTANDING + 1),
   localparam int unsigned BE_W           = DATA_WIDTH / 8
) (
   input  logic                                clk_i,
   input  logic                                rst_ni,
   input  logic [NSLAVE-1:0][ADDR_WIDTH-1:0]   addr_start_i,
   input  logic [NSLAVE-1:0][ADDR_WIDTH-1:0]   addr_end_i,
   input  logic [IDX_W-1:0]                    default_idx_i,
   input  logic                                m_req_i,
   input  logic                                m_we_i,
   input  logic [ADDR_WIDTH-1:0]               m_addr_i,
   input  logic [BE_W-1:0]                     m_be_i,
   input  logic [DATA_WIDTH-1:0]               m_wdata_i,
   output logic                                m_gnt_o,
   output logic                                m_rvalid_o,
   output logic                                m_err_o,
   output logic [DATA_WIDTH-1:0]               m_rdata_o,
   output logic [NSLAVE-1:0]                   s_req_o,
   output logic [ADDR_WIDTH-1:0]               s_addr_o,
   output logic                                s_we_o,
   output logic [BE_W-1:0]                     s_be_o,
   output logic [DATA_WIDTH-1:0]               s_wdata_o,
   input  logic [NSLAVE-1:0]                   s_gnt_i,
   input  logic [NSLAVE-1:0]                   s_rvalid_i,
   input  logic [NSLAVE-1:0]                   s_err_i,
   input  logic [NSLAVE-1:0][DATA_WIDTH-1:0]   s_rdata_i,
   output logic [CNT_W-1:0]                    outstanding_o,
   output logic                                spurious_o
);

   localparam int unsigned TGT_W = $clog2(NSLAVE + 1);
   localparam logic [TGT_W-1:0] ERR_TGT = TGT_W'(NSLAVE);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   // Lowest matching rule wins; an out-of-range fallback index is sent to the
   // error responder rather than to a non-existent port.
   function automatic logic [TGT_W-1:0] decode_target(
      input logic [ADDR_WIDTH-1:0]             addr,
      input logic [NSLAVE-1:0][ADDR_WIDTH-1:0] starts,
      input logic [NSLAVE-1:0][ADDR_WIDTH-1:0] ends,
      input logic [IDX_W-1:0]                  dflt
   );
      logic [TGT_W-1:0] tgt;
      if (ERR_RESP_EN || (TGT_W'(dflt) >= ERR_TGT)) begin
         tgt = ERR_TGT;
      end else begin
         tgt = TGT_W'(dflt);
      end
      for (int k = NSLAVE - 1; k >= 0; k--) begin
         if ((addr >= starts[k]) && (addr < ends[k])) begin
            tgt = TGT_W'(k);
         end
      end
      return tgt;
   endfunction

   logic [CNT_W-1:0]      cnt_r;
   logic [CNT_W-1:0]      cnt_nxt_s;
   logic [TGT_W-1:0]      tgt_r;
   logic [TGT_W-1:0]      tgt_nxt_s;
   logic                  err_pend_r;
   logic                  err_pend_nxt_s;
   logic [TGT_W-1:0]      tgt_dec_s;
   logic [IDX_W-1:0]      dec_idx_s;
   logic [IDX_W-1:0]      tgt_idx_s;
   logic                  dec_is_err_s;
   logic                  tgt_is_err_s;
   logic                  cnt_nz_s;
   logic                  accept_s;
   logic                  hs_s;
   logic                  gnt_s;
   logic [NSLAVE-1:0]     s_req_s;
   logic                  rvalid_s;
   logic                  err_s;
   logic [DATA_WIDTH-1:0] rdata_s;
   logic                  spur_s;

   assign tgt_dec_s    = decode_target(m_addr_i, addr_start_i, addr_end_i, default_idx_i);
   assign dec_is_err_s = (tgt_dec_s == ERR_TGT);
   assign dec_idx_s    = IDX_W'(tgt_dec_s);
   assign tgt_is_err_s = (tgt_r == ERR_TGT);
   assign tgt_idx_s    = IDX_W'(tgt_r);
   assign cnt_nz_s     = (cnt_r != '0);

   // A target change must wait for the pipe to drain, which keeps responses in order.
   assign accept_s = (cnt_r < CNT_MAX) && (!cnt_nz_s || (tgt_dec_s == tgt_r));
   assign hs_s     = m_req_i & gnt_s;

   // Request routing and grant return.
   always_comb begin
      s_req_s = '0;
      gnt_s   = 1'b0;
      if (rst_ni && accept_s) begin
         if (dec_is_err_s) begin
            gnt_s = m_req_i;
         end else begin
            s_req_s[dec_idx_s] = m_req_i;
            gnt_s              = s_gnt_i[dec_idx_s];
         end
      end else begin
         s_req_s = '0;
         gnt_s   = 1'b0;
      end
   end

   // Response selection from the current target; nothing is forwarded with no transaction open.
   always_comb begin
      rvalid_s = 1'b0;
      rdata_s  = '0;
      err_s    = 1'b0;
      if (!rst_ni) begin
         rvalid_s = 1'b0;
      end else if (tgt_is_err_s) begin
         rvalid_s = err_pend_r & cnt_nz_s;
         err_s    = 1'b1;
      end else begin
         rvalid_s = s_rvalid_i[tgt_idx_s] & cnt_nz_s;
         rdata_s  = s_rdata_i[tgt_idx_s];
         err_s    = s_err_i[tgt_idx_s];
      end
   end

   // Flag any slave response that cannot belong to an open transaction.
   always_comb begin
      spur_s = 1'b0;
      for (int k = 0; k < NSLAVE; k++) begin
         if (s_rvalid_i[k] && (tgt_is_err_s || !cnt_nz_s || (tgt_idx_s != IDX_W'(k)))) begin
            spur_s = 1'b1;
         end else begin
            spur_s = spur_s;
         end
      end
      if (!rst_ni) begin
         spur_s = 1'b0;
      end else begin
         spur_s = spur_s;
      end
   end

   // Next-state for outstanding count, target and error-pending flag.
   always_comb begin
      cnt_nxt_s      = cnt_r;
      tgt_nxt_s      = tgt_r;
      err_pend_nxt_s = hs_s & dec_is_err_s;
      case ({hs_s, rvalid_s})
         2'b10:   cnt_nxt_s = cnt_r + CNT_ONE;
         2'b01:   cnt_nxt_s = cnt_r - CNT_ONE;
         default: cnt_nxt_s = cnt_r;
      endcase
      if (hs_s) begin
         tgt_nxt_s = tgt_dec_s;
      end else begin
         tgt_nxt_s = tgt_r;
      end
   end

   // Tracking state registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_r      <= '0;
         tgt_r      <= '0;
         err_pend_r <= 1'b0;
      end else begin
         cnt_r      <= cnt_nxt_s;
         tgt_r      <= tgt_nxt_s;
         err_pend_r <= err_pend_nxt_s;
      end
   end

   assign m_gnt_o       = gnt_s;
   assign m_rvalid_o    = rvalid_s;
   assign m_err_o       = err_s;
   assign m_rdata_o     = rdata_s;
   assign s_req_o       = s_req_s;
   assign s_addr_o      = m_addr_i;
   assign s_we_o        = m_we_i;
   assign s_be_o        = m_be_i;
   assign s_wdata_o     = m_wdata_i;
   assign outstanding_o = cnt_r;
   assign spurious_o    = spur_s;

endmodule

// File: tb/tb_gr_heep_obi_demux.sv
// Directed bench for gr_heep_obi_demux: error-responder instance plus a
// default-slave instance sharing the same stimulus; responses via a scoreboard queue.
module tb_gr_heep_obi_demux;

   localparam int NS = 6;
   localparam int AW = 32;
   localparam int DW = 32;

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
   } resp_t;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [NS-1:0][AW-1:0] a_start, a_end;
   logic              m_req = 1'b0, m_we = 1'b0;
   logic [AW-1:0]     m_addr = '0;
   logic [3:0]        m_be = 4'hF;
   logic [DW-1:0]     m_wdata = 32'h1234_5678;
   logic [NS-1:0]     s_gnt = '0, s_rvalid = '0, s_err = '0;
   logic [NS-1:0][DW-1:0] s_rdata;

   logic gnt0, rv0, err0, we0, spur0;
   logic [DW-1:0] rd0, wd0;
   logic [NS-1:0] sreq0;
   logic [AW-1:0] sa0;
   logic [3:0] be0;
   logic [2:0] out0;
   logic gnt1, rv1, err1, we1, spur1;
   logic [DW-1:0] rd1, wd1;
   logic [NS-1:0] sreq1;
   logic [AW-1:0] sa1;
   logic [3:0] be1;
   logic [2:0] out1;

   int n_cmp = 0;
   int n_mis = 0;
   resp_t exp_q[$];

   always #5 clk = ~clk;

   gr_heep_obi_demux #(.NSLAVE(NS), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                       .MAX_OUTSTANDING(4), .ERR_RESP_EN(1'b1)) dut0 (
      .clk_i(clk), .rst_ni(rst_n), .addr_start_i(a_start), .addr_end_i(a_end),
      .default_idx_i(3'd5), .m_req_i(m_req), .m_we_i(m_we), .m_addr_i(m_addr),
      .m_be_i(m_be), .m_wdata_i(m_wdata), .m_gnt_o(gnt0), .m_rvalid_o(rv0),
      .m_err_o(err0), .m_rdata_o(rd0), .s_req_o(sreq0), .s_addr_o(sa0),
      .s_we_o(we0), .s_be_o(be0), .s_wdata_o(wd0), .s_gnt_i(s_gnt),
      .s_rvalid_i(s_rvalid), .s_err_i(s_err), .s_rdata_i(s_rdata),
      .outstanding_o(out0), .spurious_o(spur0));

   gr_heep_obi_demux #(.NSLAVE(NS), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                       .MAX_OUTSTANDING(4), .ERR_RESP_EN(1'b0)) dut1 (
      .clk_i(clk), .rst_ni(rst_n), .addr_start_i(a_start), .addr_end_i(a_end),
      .default_idx_i(3'd5), .m_req_i(m_req), .m_we_i(m_we), .m_addr_i(m_addr),
      .m_be_i(m_be), .m_wdata_i(m_wdata), .m_gnt_o(gnt1), .m_rvalid_o(rv1),
      .m_err_o(err1), .m_rdata_o(rd1), .s_req_o(sreq1), .s_addr_o(sa1),
      .s_we_o(we1), .s_be_o(be1), .s_wdata_o(wd1), .s_gnt_i(s_gnt),
      .s_rvalid_i(s_rvalid), .s_err_i(s_err), .s_rdata_i(s_rdata),
      .outstanding_o(out1), .spurious_o(spur1));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_resp(input logic [31:0] d, input logic e);
      resp_t r;
      r.rdata = d;
      r.err   = e;
      exp_q.push_back(r);
   endtask

   // Called in a cycle where a response is expected on the master side.
   task automatic pop_resp(input string tag);
      resp_t r;
      chk({tag, "_rvalid"}, 64'(rv0), 64'd1);
      chk({tag, "_qnonempty"}, 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
         r = exp_q.pop_front();
         chk({tag, "_rdata"}, 64'(rd0), 64'(r.rdata));
         chk({tag, "_err"}, 64'(err0), 64'(r.err));
      end
   endtask

   initial begin
      for (int k = 0; k < NS; k++) begin
         a_start[k] = 32'(k) * 32'h1000;
         a_end[k]   = (32'(k) + 32'd1) * 32'h1000;
         s_rdata[k] = 32'h0;
      end
      // reset with a request pending to an unmapped address
      m_req  = 1'b1;
      m_addr = 32'hF000_0000;
      #2;
      chk("rst_outstanding", 64'(out0), 64'd0);
      chk("rst_gnt", 64'(gnt0), 64'd0);
      chk("rst_rvalid", 64'(rv0), 64'd0);
      chk("rst_sreq", 64'(sreq0), 64'd0);
      chk("rst_spurious", 64'(spur0), 64'd0);
      chk("rst_addr_bcast", 64'(sa0), 64'hF000_0000);
      chk("rst_wdata_bcast", 64'(wd0), 64'h1234_5678);
      tick();
      rst_n = 1'b1;
      m_req = 1'b0;
      tick();

      // single read to slave 2
      m_req = 1'b1; m_addr = 32'h2004; s_gnt = 6'b000100;
      #2;
      chk("t1_sreq", 64'(sreq0), 64'b000100);
      chk("t1_gnt", 64'(gnt0), 64'd1);
      chk("t1_out0", 64'(out0), 64'd0);
      push_resp(32'hCAFE_F00D, 1'b0);
      tick();
      m_req = 1'b0; s_gnt = '0;
      #2;
      chk("t1_out1", 64'(out0), 64'd1);
      chk("t1_norv", 64'(rv0), 64'd0);
      tick();
      s_rvalid = 6'b000100; s_rdata[2] = 32'hCAFE_F00D;
      #2;
      pop_resp("t1");
      chk("t1_nospur", 64'(spur0), 64'd0);
      tick();
      s_rvalid = '0;
      #2;
      chk("t1_out_end", 64'(out0), 64'd0);

      // fill to MAX_OUTSTANDING on slave 1, then one more
      tick();
      m_req = 1'b1; m_addr = 32'h1000; s_gnt = 6'b000010;
      for (int i = 0; i < 4; i++) begin
         #2;
         chk("t2_gnt", 64'(gnt0), 64'd1);
         chk("t2_sreq", 64'(sreq0), 64'b000010);
         push_resp(32'h1111_0000 + 32'(i), 1'b0);
         tick();
      end
      #2;
      chk("t2_full_gnt", 64'(gnt0), 64'd0);
      chk("t2_full_sreq", 64'(sreq0), 64'd0);
      chk("t2_full_out", 64'(out0), 64'd4);
      tick();
      s_rvalid = 6'b000010; s_rdata[1] = 32'h1111_0000;
      #2;
      pop_resp("t2_r0");
      chk("t2_same_cycle_gnt", 64'(gnt0), 64'd0);
      tick();
      s_rvalid = '0;
      #2;
      chk("t2_resume_gnt", 64'(gnt0), 64'd1);
      chk("t2_resume_out", 64'(out0), 64'd3);
      push_resp(32'h1111_0004, 1'b0);
      tick();
      m_req = 1'b0; s_gnt = '0;
      #2;
      chk("t2_refill_out", 64'(out0), 64'd4);
      for (int i = 1; i <= 4; i++) begin
         s_rvalid = 6'b000010; s_rdata[1] = 32'h1111_0000 + 32'(i);
         #2;
         pop_resp("t2_drain");
         tick();
      end
      s_rvalid = '0;
      #2;
      chk("t2_out_end", 64'(out0), 64'd0);

      // target switch from slave 0 to slave 3 waits for drain
      tick();
      m_req = 1'b1; m_addr = 32'h0100; s_gnt = 6'b001001;
      push_resp(32'h0000_00A0, 1'b0);
      tick();
      push_resp(32'h0000_00A1, 1'b0);
      tick();
      m_addr = 32'h3000;
      #2;
      chk("t3_stall_gnt", 64'(gnt0), 64'd0);
      chk("t3_stall_sreq", 64'(sreq0), 64'd0);
      tick();
      s_rvalid = 6'b000001; s_rdata[0] = 32'h0000_00A0;
      #2;
      pop_resp("t3_a0");
      chk("t3_stall2_gnt", 64'(gnt0), 64'd0);
      tick();
      s_rdata[0] = 32'h0000_00A1;
      #2;
      pop_resp("t3_a1");
      chk("t3_stall3_gnt", 64'(gnt0), 64'd0);
      chk("t3_out1", 64'(out0), 64'd1);
      tick();
      s_rvalid = '0;
      #2;
      chk("t3_switch_gnt", 64'(gnt0), 64'd1);
      chk("t3_switch_sreq", 64'(sreq0), 64'b001000);
      push_resp(32'h0000_00B3, 1'b1);
      tick();
      m_req = 1'b0; s_gnt = '0;
      s_rvalid = 6'b001000; s_rdata[3] = 32'h0000_00B3; s_err = 6'b001000;
      #2;
      pop_resp("t3_b3");
      tick();
      s_rvalid = '0; s_err = '0;

      // unmapped: error responder on dut0, default slave 5 on dut1
      m_req = 1'b1; m_addr = 32'hF000_0000;
      #2;
      chk("t4_gnt", 64'(gnt0), 64'd1);
      chk("t4_nosreq", 64'(sreq0), 64'd0);
      chk("t5_dflt_sreq", 64'(sreq1), 64'b100000);
      push_resp(32'h0, 1'b1);
      tick();
      #2;
      chk("t4_b2b_gnt", 64'(gnt0), 64'd1);
      pop_resp("t4_e0");
      push_resp(32'h0, 1'b1);
      tick();
      m_req = 1'b0;
      #2;
      pop_resp("t4_e1");
      chk("t4_out1", 64'(out0), 64'd1);
      tick();
      #2;
      chk("t4_out_end", 64'(out0), 64'd0);
      chk("t4_norv", 64'(rv0), 64'd0);

      // spurious response from slave 4 while slave 1 is the target
      m_req = 1'b1; m_addr = 32'h1010; s_gnt = 6'b000010;
      push_resp(32'h0000_0055, 1'b0);
      tick();
      m_req = 1'b0; s_gnt = '0; s_rvalid = 6'b010000;
      #2;
      chk("t6_spur", 64'(spur0), 64'd1);
      chk("t6_norv", 64'(rv0), 64'd0);
      chk("t6_out", 64'(out0), 64'd1);
      tick();
      s_rvalid = '0;
      #2;
      chk("t6_spur_clear", 64'(spur0), 64'd0);
      chk("t6_out_kept", 64'(out0), 64'd1);
      tick();
      s_rvalid = 6'b000010; s_rdata[1] = 32'h0000_0055;
      #2;
      pop_resp("t6_r");
      tick();
      #2;
      chk("t6_idle_spur", 64'(spur0), 64'd1);
      chk("t6_idle_norv", 64'(rv0), 64'd0);
      tick();
      s_rvalid = '0;

      // reset with three transactions in flight
      m_req = 1'b1; m_addr = 32'h1000; s_gnt = 6'b000010;
      tick();
      tick();
      tick();
      #2;
      chk("t7_out3", 64'(out0), 64'd3);
      #1;
      rst_n = 1'b0; s_rvalid = 6'b000010;
      #1;
      chk("t7_rst_out", 64'(out0), 64'd0);
      chk("t7_rst_gnt", 64'(gnt0), 64'd0);
      chk("t7_rst_rv", 64'(rv0), 64'd0);
      chk("t7_rst_sreq", 64'(sreq0), 64'd0);
      tick();
      rst_n = 1'b1; m_req = 1'b0; s_gnt = '0;
      #2;
      chk("t7_late_spur", 64'(spur0), 64'd1);
      chk("t7_late_norv", 64'(rv0), 64'd0);
      chk("t7_late_out", 64'(out0), 64'd0);
      tick();
      s_rvalid = '0;
      chk("sb_empty", 64'(exp_q.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
